// File: rtl/rv32i_pkg.sv
// Shared types and constants for the RV32I writeback slice.
package rv32i_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        WB_ALU  = 2'b00,
        WB_LOAD = 2'b01,
        WB_PC4  = 2'b10,
        WB_IMM  = 2'b11
    } wb_sel_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [0:0] {
        WB_IDLE      = 1'b0,
        WB_LOAD_WAIT = 1'b1
    } wb_state_t;

endpackage

// File: rtl/rv32i_load_fmt.sv
// Combinational load data formatter: byte/halfword lane select with sign or zero extension.
module rv32i_load_fmt
    import rv32i_pkg::*;
(
    input  logic [XLEN-1:0] word,
    input  logic [2:0]      funct3,
    input  logic [1:0]      addr_lsb,
    output logic [XLEN-1:0] data,
    output logic            illegal
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word[7:0];
        case (addr_lsb)
            2'd0:    byte_sel = word[7:0];
            2'd1:    byte_sel = word[15:8];
            2'd2:    byte_sel = word[23:16];
            default: byte_sel = word[31:24];
        endcase
        half_sel = addr_lsb[1] ? word[31:16] : word[15:0];
    end

    // Illegal encodings pass the raw word through so the write data is still defined.
    always_comb begin
        data    = word;
        illegal = 1'b0;
        case (funct3)
            F3_LB:   data = {{24{byte_sel[7]}}, byte_sel};
            F3_LBU:  data = {24'd0, byte_sel};
            F3_LH:   data = {{16{half_sel[15]}}, half_sel};
            F3_LHU:  data = {16'd0, half_sel};
            F3_LW:   data = word;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/rv32i_wb_stage.sv
// RV32I writeback stage: result select, load wait/format, registered register-file write pulse.
// Defining RV32I_WB_INSTRET_EN adds the 64-bit retired-instruction counter and its port.
//
// state        | meaning
// -------------+---------------------------------------------------------
// ST_IDLE      | ready for a new instruction; non-loads retire next cycle
// ST_LOAD_WAIT | load accepted, waiting for mem_rvalid
module rv32i_wb_stage
    import rv32i_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      rd_reg,
    input  logic            rd_we,
    input  logic [1:0]      wb_sel,
    input  logic [XLEN-1:0] alu_result,
    input  logic [XLEN-1:0] pc_plus4,
    input  logic [XLEN-1:0] imm,
    input  logic [2:0]      load_funct3,
    input  logic [1:0]      addr_lsb,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            mem_rvalid,
    output logic            wb_enable,
    output logic [4:0]      wb_reg,
    output logic [XLEN-1:0] wb_data,
    output logic            load_err
`ifdef RV32I_WB_INSTRET_EN
    ,
    output logic [63:0]     instret
`endif
);

    localparam logic [0:0] ST_IDLE      = WB_IDLE;
    localparam logic [0:0] ST_LOAD_WAIT = WB_LOAD_WAIT;

    logic [0:0]      state;
    logic            accept;
    logic [4:0]      ld_rd;
    logic            ld_we;
    logic [2:0]      ld_f3;
    logic [1:0]      ld_lsb;
    logic [XLEN-1:0] sel_data;
    logic [XLEN-1:0] fmt_data;
    logic            fmt_illegal;

    assign in_ready = (state == ST_IDLE) && reset;
    assign accept   = in_valid && in_ready;

    always_comb begin
        case (wb_sel_t'(wb_sel))
            WB_PC4:  sel_data = pc_plus4;
            WB_IMM:  sel_data = imm;
            default: sel_data = alu_result;
        endcase
    end

    rv32i_load_fmt u_load_fmt (
        .word     (mem_rdata),
        .funct3   (ld_f3),
        .addr_lsb (ld_lsb),
        .data     (fmt_data),
        .illegal  (fmt_illegal)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= ST_IDLE;
            wb_enable <= 1'b0;
            wb_reg    <= 5'd0;
            wb_data   <= '0;
            load_err  <= 1'b0;
            ld_rd     <= 5'd0;
            ld_we     <= 1'b0;
            ld_f3     <= 3'd0;
            ld_lsb    <= 2'd0;
        end else begin
            wb_enable <= 1'b0;
            load_err  <= 1'b0;
            if (state == ST_IDLE) begin
                if (accept) begin
                    if (wb_sel == WB_LOAD) begin
                        ld_rd  <= rd_reg;
                        ld_we  <= rd_we;
                        ld_f3  <= load_funct3;
                        ld_lsb <= addr_lsb;
                        state  <= ST_LOAD_WAIT;
                    end else begin
                        wb_reg    <= rd_reg;
                        wb_data   <= sel_data;
                        wb_enable <= rd_we && (rd_reg != 5'd0);
                    end
                end
            end else if (mem_rvalid) begin
                wb_reg    <= ld_rd;
                wb_data   <= fmt_data;
                wb_enable <= ld_we && (ld_rd != 5'd0) && !fmt_illegal;
                load_err  <= fmt_illegal;
                state     <= ST_IDLE;
            end
        end
    end

`ifdef RV32I_WB_INSTRET_EN
    logic retire;

    // Every retirement slot counts, including x0 targets and illegal loads.
    assign retire = (accept && (wb_sel != WB_LOAD)) || ((state == ST_LOAD_WAIT) && mem_rvalid);

    always_ff @(posedge clk) begin
        if (!reset) begin
            instret <= 64'd0;
        end else if (retire) begin
            instret <= instret + 64'd1;
        end
    end
`endif

endmodule
